alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one alu instance (2..8).
REQ-002 Parameter DATA_W, default 32, operand/result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 req_opcode  input  NUM_REQ x alu_opcode_e  per-requester opcode (warp_pkg).
REQ-008 req_op1, req_op2, req_op3  input  NUM_REQ x DATA_W each  per-requester operands.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_id  output  clog2(NUM_REQ)  index of requester owning the result.
REQ-012 resp_result  output  DATA_W  captured alu result.
REQ-013 resp_overflow  output  1  captured alu overflow flag.
REQ-014 alu_opcode  output  alu_opcode_e  to alu opcode.
REQ-015 alu_operand1, alu_operand2, alu_operand3  output  DATA_W each  to alu operands.
REQ-016 alu_result, alu_overflow, alu_ready  input  DATA_W, 1, 1  from alu.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP.
REQ-018 IDLE: if any req_valid, winner = first set req_valid searching round-robin from (last_grant+1) mod NUM_REQ; req_ready[winner]=1 combinationally that cycle only; all other req_ready=0.
REQ-019 IDLE accept edge: latch winner opcode/operands into issue registers, latch winner into last_grant and resp_id, go EXEC; no req_valid -> stay IDLE, req_ready all 0.
REQ-020 req_ready SHALL be 0 for all requesters in EXEC and RESP; requesters hold req_valid and payload until accepted.
REQ-021 alu_opcode/alu_operand1..3 SHALL be driven from the issue registers and stay stable from the cycle after accept until EXEC exits.
REQ-022 EXEC: alu_ready sampled 1 on a rising edge at least one cycle after entry -> capture alu_result/alu_overflow into resp_result/resp_overflow, go RESP; otherwise remain in EXEC indefinitely.
REQ-023 RESP: resp_valid=1, resp_id/resp_result/resp_overflow stable; resp_ready=1 -> go IDLE next edge; resp_ready=0 -> hold.
REQ-024 resp_valid SHALL be 0 in IDLE and EXEC.
REQ-025 Minimum latency: accept edge to resp_valid = 2 cycles; max throughput one operation per 3 cycles.
REQ-026 Round-robin pointer wraps NUM_REQ-1 -> 0; one continuously requesting port never starves others: each waits at most NUM_REQ-1 grants.
REQ-027 req_valid dropping on a non-granted port has no effect; a new req_valid arriving during EXEC/RESP waits for IDLE.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_overflow=0, alu_opcode=OP_ADD, alu_operands=0, last_grant=NUM_REQ-1 (port 0 wins first).
REQ-029 Reset mid-EXEC or mid-RESP SHALL abandon the operation with no response; requester re-issues.

Configuration
REQ-030 Macro ALU_ARB_PERF_EN defined: add outputs perf_ops (32 bits, count of resp_valid&resp_ready handshakes) and perf_stall (32 bits, count of RESP cycles with resp_ready=0), both saturating at all-ones, reset to 0.
REQ-031 ALU_ARB_PERF_EN undefined: perf ports and counters absent; all other behaviour identical.

Verification
REQ-032 Single request port 2, OP_ADD 0x10+0x20, alu_ready=1 -> req_ready[2] one cycle, resp_valid 2 cycles later, resp_id=2, resp_result=0x30.
REQ-033 All ports valid after reset, resp_ready=1 -> grant order 0,1,2,3,0; each resp_id matches grant.
REQ-034 OP_FMA 2,3,4 with alu_ready held low 5 cycles -> alu operands stable throughout, resp_result=0xA, resp_valid only after alu_ready.
REQ-035 resp_ready low 4 cycles in RESP with port 1 valid -> resp fields stable, req_ready[1]=0 until IDLE; perf_stall=4 when ALU_ARB_PERF_EN.
REQ-036 rst_n asserted mid-EXEC -> resp_valid=0, alu_opcode=OP_ADD immediately; next grant goes to port 0.
REQ-037 alu_overflow=1 with OP_MUL 0xFFFFFFFF*2 -> resp_overflow=1 for that response only; next response overflow=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU between NUM_REQ requesters. A round-robin arbiter picks one
// pending request while idle, copies its opcode and operands into issue
// registers that drive the ALU, waits for the ALU to report ready, captures
// the result and overflow flag, and presents them on a valid/ready response
// port tagged with the owning requester's index. Only one operation is in
// flight at any time.
//
// Optional feature macro: ALU_ARB_PERF_EN
//   When defined, two saturating 32-bit performance counters are added:
//   perf_ops (completed response handshakes) and perf_stall (response cycles
//   in which the consumer held resp_ready low).
//
// Parameters
//   NUM_REQ : number of requesters (2..8)
//   DATA_W  : operand / result width
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid  [NUM_REQ]        : per-requester request
//   req_ready  [NUM_REQ]        : per-requester accept (one-hot or zero)
//   req_opcode [NUM_REQ]        : per-requester opcode
//   req_op1/2/3 [NUM_REQ]       : per-requester operands
//   resp_valid / resp_ready     : response handshake
//   resp_id                     : index of the requester owning the response
//   resp_result / resp_overflow : captured ALU result and overflow flag
//   alu_opcode, alu_operand1..3 : issue registers driving the ALU
//   alu_result, alu_overflow    : ALU outputs
//   alu_ready                   : ALU result is valid this cycle
//   perf_ops, perf_stall        : performance counters (ALU_ARB_PERF_EN only)
// ----------------------------------------------------------------------------

package warp_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_FMA = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SHL = 3'd7
  } alu_opcode_e;

endpackage

module alu_arbiter
  import warp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,

  input  logic        [NUM_REQ-1:0]              req_valid,
  output logic        [NUM_REQ-1:0]              req_ready,
  input  alu_opcode_e [NUM_REQ-1:0]              req_opcode,
  input  logic        [NUM_REQ-1:0][DATA_W-1:0]  req_op1,
  input  logic        [NUM_REQ-1:0][DATA_W-1:0]  req_op2,
  input  logic        [NUM_REQ-1:0][DATA_W-1:0]  req_op3,

  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]        resp_id,
  output logic [DATA_W-1:0]                 resp_result,
  output logic                              resp_overflow,

  output alu_opcode_e                       alu_opcode,
  output logic [DATA_W-1:0]                 alu_operand1,
  output logic [DATA_W-1:0]                 alu_operand2,
  output logic [DATA_W-1:0]                 alu_operand3,
  input  logic [DATA_W-1:0]                 alu_result,
  input  logic                              alu_overflow,
  input  logic                              alu_ready
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]                       perf_ops,
  output logic [31:0]                       perf_stall
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state;
  logic [ID_W-1:0]    last_grant;

  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_req;
  logic [NUM_REQ-1:0] pick_vec;
  logic [ID_W-1:0]    winner;

  // Round-robin pick: requests strictly above last_grant take priority; if
  // none exist the search wraps and the lowest-indexed request wins. This is
  // equivalent to scanning from last_grant+1 modulo NUM_REQ without needing
  // a modulo on a non-power-of-two count.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_mask[i] = (i > int'(last_grant));
    end
    upper_req = req_valid & upper_mask;
    pick_vec  = (|upper_req) ? upper_req : req_valid;
    winner    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // The accept strobe is combinational so the requester sees it in the same
  // cycle it is chosen. It is gated by rst_n so that reset forces it low
  // even though the state register is already IDLE.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && (|req_valid)) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Main controller. The alu_* outputs are the issue registers themselves,
  // so they hold the accepted operation unchanged from the cycle after
  // accept until the next accept. The ALU handshake is only sampled in
  // EXEC, which is never the accept edge, so a stale alu_ready from a
  // previous operation cannot complete a new one early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= ID_W'(NUM_REQ - 1);
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_result   <= '0;
      resp_overflow <= 1'b0;
      alu_opcode    <= OP_ADD;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
      alu_operand3  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            alu_opcode   <= req_opcode[winner];
            alu_operand1 <= req_op1[winner];
            alu_operand2 <= req_op2[winner];
            alu_operand3 <= req_op3[winner];
            last_grant   <= winner;
            resp_id      <= winner;
            state        <= EXEC;
          end
        end

        EXEC: begin
          if (alu_ready) begin
            resp_result   <= alu_result;
            resp_overflow <= alu_overflow;
            resp_valid    <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Both counters stick at all-ones instead of wrapping so that a long run
  // never reports a misleadingly small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (resp_valid && resp_ready && (perf_ops != '1)) begin
        perf_ops <= perf_ops + 32'd1;
      end
      if (resp_valid && !resp_ready && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter with directed scenarios followed by randomized traffic.
// A transaction-level model tracks the single operation in flight and the
// round-robin pointer; a compare process checks every DUT output against it
// on each falling clock edge. A simple ALU stub answers the DUT's issue
// outputs combinationally, while alu_ready is driven by the bench.
// ----------------------------------------------------------------------------

module tb_alu_arbiter;
  import warp_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                               clk = 1'b0;
  logic                               rst_n = 1'b0;
  logic        [NUM_REQ-1:0]          req_valid = '0;
  logic        [NUM_REQ-1:0]          req_ready;
  alu_opcode_e [NUM_REQ-1:0]          req_opcode;
  logic        [NUM_REQ-1:0][DATA_W-1:0] req_op1;
  logic        [NUM_REQ-1:0][DATA_W-1:0] req_op2;
  logic        [NUM_REQ-1:0][DATA_W-1:0] req_op3;
  logic                               resp_valid;
  logic                               resp_ready = 1'b0;
  logic [ID_W-1:0]                    resp_id;
  logic [DATA_W-1:0]                  resp_result;
  logic                               resp_overflow;
  alu_opcode_e                        alu_opcode;
  logic [DATA_W-1:0]                  alu_operand1;
  logic [DATA_W-1:0]                  alu_operand2;
  logic [DATA_W-1:0]                  alu_operand3;
  logic [DATA_W-1:0]                  alu_result;
  logic                               alu_overflow;
  logic                               alu_ready = 1'b0;
  logic [DATA_W:0]                    alu_calc;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]                        perf_ops;
  logic [31:0]                        perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_op3      (req_op3),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_result  (resp_result),
    .resp_overflow(resp_overflow),
    .alu_opcode   (alu_opcode),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_operand3 (alu_operand3),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_ready    (alu_ready)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_ops     (perf_ops),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: {overflow, result}. Overflow means the exact result does
  // not fit in 32 bits.
  function automatic logic [DATA_W:0] aluFn(alu_opcode_e op, logic [31:0] a,
                                            logic [31:0] b, logic [31:0] c);
    logic [63:0] wide;
    case (op)
      OP_ADD:  wide = {32'b0, a} + {32'b0, b};
      OP_SUB:  wide = {32'b0, a} - {32'b0, b};
      OP_MUL:  wide = {32'b0, a} * {32'b0, b};
      OP_FMA:  wide = {32'b0, a} * {32'b0, b} + {32'b0, c};
      OP_AND:  wide = {32'b0, a & b};
      OP_OR:   wide = {32'b0, a | b};
      OP_XOR:  wide = {32'b0, a ^ b};
      OP_SHL:  wide = {32'b0, a} << b[4:0];
      default: wide = 64'b0;
    endcase
    return {|wide[63:32], wide[31:0]};
  endfunction

  assign alu_calc     = aluFn(alu_opcode, alu_operand1, alu_operand2, alu_operand3);
  assign alu_result   = alu_calc[DATA_W-1:0];
  assign alu_overflow = alu_calc[DATA_W];

  // Round robin by definition: first set request scanning from last+1, wrapping.
  function automatic int rrPick(int last, logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int p;
      p = (last + k) % NUM_REQ;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  // Transaction model: at most one operation in flight, either waiting for
  // the ALU or waiting for the consumer.
  int          m_last   = NUM_REQ - 1;
  bit          m_busy   = 1'b0;
  bit          m_resp   = 1'b0;
  int          m_owner  = 0;
  alu_opcode_e m_op     = OP_ADD;
  logic [31:0] m_a = '0, m_b = '0, m_c = '0;
  logic [31:0] m_result = '0;
  logic        m_ovf    = 1'b0;
  int          m_accept = -1;
  logic [31:0] m_ops    = '0;
  logic [31:0] m_stall  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = NUM_REQ - 1; m_busy = 1'b0; m_resp = 1'b0; m_owner = 0;
      m_op = OP_ADD; m_a = '0; m_b = '0; m_c = '0;
      m_result = '0; m_ovf = 1'b0; m_accept = -1; m_ops = '0; m_stall = '0;
    end else begin
      m_accept = -1;
      if (!m_busy) begin
        int w;
        w = rrPick(m_last, req_valid);
        if (w >= 0) begin
          m_busy = 1'b1; m_resp = 1'b0; m_owner = w; m_last = w; m_accept = w;
          m_op = req_opcode[w]; m_a = req_op1[w]; m_b = req_op2[w]; m_c = req_op3[w];
        end
      end else if (!m_resp) begin
        if (alu_ready) begin
          {m_ovf, m_result} = aluFn(m_op, m_a, m_b, m_c);
          m_resp = 1'b1;
        end
      end else if (resp_ready) begin
        m_busy = 1'b0; m_resp = 1'b0;
        if (m_ops != '1) m_ops = m_ops + 1;
      end else begin
        if (m_stall != '1) m_stall = m_stall + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    exp_ready = '0;
    if (rst_n && !m_busy && (|req_valid)) exp_ready[rrPick(m_last, req_valid)] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("resp_valid", 64'(resp_valid), 64'(rst_n && m_busy && m_resp));
    checkOutput("resp_id", 64'(resp_id), 64'(m_owner));
    checkOutput("resp_result", 64'(resp_result), 64'(m_result));
    checkOutput("resp_overflow", 64'(resp_overflow), 64'(m_ovf));
    checkOutput("alu_opcode", 64'(alu_opcode), 64'(m_op));
    checkOutput("alu_operand1", 64'(alu_operand1), 64'(m_a));
    checkOutput("alu_operand2", 64'(alu_operand2), 64'(m_b));
    checkOutput("alu_operand3", 64'(alu_operand3), 64'(m_c));
`ifdef ALU_ARB_PERF_EN
    checkOutput("perf_ops", 64'(perf_ops), 64'(m_ops));
    checkOutput("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0; alu_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic setReq(input int p, input alu_opcode_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
    req_opcode[p] = op; req_op1[p] = a; req_op2[p] = b; req_op3[p] = c;
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Random traffic: granted requesters drop their request, idle ones raise
  // new ones, busy-period drops exercise non-granted withdrawal, and an
  // occasional one-cycle reset abandons whatever is in flight.
  task automatic applyStimulus();
    if (!rst_n) rst_n = 1'b1;
    else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (m_accept == p) req_valid[p] = 1'b0;
      if (!req_valid[p] && ($urandom_range(0, 3) == 0)) begin
        req_valid[p] = 1'b1;
        setReq(p, alu_opcode_e'($urandom_range(0, 7)), randOperand(), randOperand(),
               randOperand());
      end else if (req_valid[p] && m_busy && ($urandom_range(0, 31) == 0)) begin
        req_valid[p] = 1'b0;
      end
    end
    alu_ready  = ($urandom_range(0, 2) != 0);
    resp_ready = ($urandom_range(0, 1) != 0);
  endtask

  initial begin
    int grants[$];
    int resps[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    for (int p = 0; p < NUM_REQ; p++) setReq(p, OP_ADD, 32'd0, 32'd0, 32'd0);

    // Reset values
    @(negedge clk);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_alu_opcode", 64'(alu_opcode), 64'(OP_ADD));
    checkOutput("rst_resp_result", 64'(resp_result), 64'd0);

    // Single ADD on port 2
    doReset();
    setReq(2, OP_ADD, 32'h10, 32'h20, 32'h0);
    req_valid = 4'b0100; alu_ready = 1'b1;
    @(negedge clk); checkOutput("t032_ready", 64'(req_ready), 64'h4);
    step(); req_valid = '0;
    @(negedge clk); checkOutput("t032_exec_valid", 64'(resp_valid), 64'd0);
    step(); resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t032_valid", 64'(resp_valid), 64'd1);
    checkOutput("t032_id", 64'(resp_id), 64'd2);
    checkOutput("t032_result", 64'(resp_result), 64'h30);
    step();

    // Everyone requesting: grant order from reset
    doReset();
    for (int p = 0; p < NUM_REQ; p++) setReq(p, OP_ADD, 32'(p), 32'd1, 32'd0);
    req_valid = '1; alu_ready = 1'b1; resp_ready = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < NUM_REQ; p++) if (req_ready[p]) grants.push_back(p);
      if (resp_valid && resp_ready) resps.push_back(int'(resp_id));
      step();
    end
    checkOutput("t033_grant_count", 64'(grants.size()), 64'd5);
    checkOutput("t033_resp_count", 64'(resps.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) checkOutput($sformatf("t033_grant%0d", i), 64'(grants[i]), 64'(exp_order[i]));
      if (i < resps.size())  checkOutput($sformatf("t033_resp%0d", i), 64'(resps[i]), 64'(exp_order[i]));
    end

    // FMA with a slow ALU
    doReset();
    setReq(0, OP_FMA, 32'd2, 32'd3, 32'd4);
    req_valid = 4'b0001; resp_ready = 1'b1;
    @(negedge clk); checkOutput("t034_ready", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      checkOutput("t034_op", 64'(alu_opcode), 64'(OP_FMA));
      checkOutput("t034_a", 64'(alu_operand1), 64'd2);
      checkOutput("t034_b", 64'(alu_operand2), 64'd3);
      checkOutput("t034_c", 64'(alu_operand3), 64'd4);
      checkOutput("t034_wait_valid", 64'(resp_valid), 64'd0);
      step();
    end
    alu_ready = 1'b1;
    @(negedge clk); checkOutput("t034_pre_valid", 64'(resp_valid), 64'd0);
    step(); alu_ready = 1'b0;
    @(negedge clk);
    checkOutput("t034_valid", 64'(resp_valid), 64'd1);
    checkOutput("t034_result", 64'(resp_result), 64'hA);
    step();

    // Consumer back-pressure while port 1 waits
    doReset();
    setReq(0, OP_ADD, 32'd1, 32'd1, 32'd0);
    req_valid = 4'b0001; alu_ready = 1'b1;
    step();
    setReq(1, OP_SUB, 32'd9, 32'd4, 32'd0);
    req_valid = 4'b0010;
    @(negedge clk); checkOutput("t035_exec_ready", 64'(req_ready), 64'd0);
    step();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      checkOutput("t035_valid", 64'(resp_valid), 64'd1);
      checkOutput("t035_result", 64'(resp_result), 64'd2);
      checkOutput("t035_hold_ready", 64'(req_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    @(negedge clk); checkOutput("t035_idle_ready", 64'(req_ready), 64'h2);
`ifdef ALU_ARB_PERF_EN
    checkOutput("t035_perf_stall", 64'(perf_stall), 64'd4);
    checkOutput("t035_perf_ops", 64'(perf_ops), 64'd1);
`endif
    step(); req_valid = '0;
    repeat (3) step();

    // Reset in the middle of an operation
    doReset();
    setReq(3, OP_SUB, 32'd7, 32'd5, 32'd0);
    req_valid = 4'b1000;
    step(); req_valid = '0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t036_valid", 64'(resp_valid), 64'd0);
    checkOutput("t036_opcode", 64'(alu_opcode), 64'(OP_ADD));
    checkOutput("t036_operand", 64'(alu_operand1), 64'd0);
    step(); step();
    rst_n = 1'b1; req_valid = '1;
    @(negedge clk); checkOutput("t036_first_grant", 64'(req_ready), 64'h1);
    step();

    // Overflow flag belongs to one response only
    doReset();
    setReq(0, OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0);
    req_valid = 4'b0001; alu_ready = 1'b1; resp_ready = 1'b1;
    step();
    setReq(0, OP_ADD, 32'd1, 32'd2, 32'd0);
    step();
    @(negedge clk);
    checkOutput("t037_ovf1", 64'(resp_overflow), 64'd1);
    checkOutput("t037_res1", 64'(resp_result), 64'hFFFF_FFFE);
    step(); step(); req_valid = '0;
    step();
    @(negedge clk);
    checkOutput("t037_valid2", 64'(resp_valid), 64'd1);
    checkOutput("t037_ovf2", 64'(resp_overflow), 64'd0);
    checkOutput("t037_res2", 64'(resp_result), 64'd3);
    step();

    // Randomized traffic against the model
    doReset();
    repeat (3000) begin
      applyStimulus();
      step();
    end
    req_valid = '0; resp_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
